phy_tx_mii_framer: RTL and testbench
====================================

// Module: phy_tx_mii_framer
// PURPOSE
//  Drains one per-port PHY-TX FIFO and serialises frames onto a 100 Mb/s MII transmit interface.
//  Sits downstream of the PHY-TX FIFO that the control-frame issuer and forwarding path write into.
//  Each FIFO word is {del, data[7:0]}; del marks the last byte (FCS tail) of a frame.
//  Inserts preamble and SFD, emits bytes low nibble first, signals underrun, and enforces the inter-frame gap (IFG).
// PARAMETERS
//  PRE_NIBBLES  15  preamble nibbles (0x5) sent before the SFD
//  IFG_NIBBLES  24  idle nibbles after each frame (96 bit times)
//  CNT_W        16  width of the statistics counters
// PORTS
//  clk           in   1      MII TX clock, 25 MHz; the FIFO read side is in this domain
//  arst_n        in   1      asynchronous, active-low reset
//  enable        in   1      level; 0 = do not start a new frame (a frame in flight completes)
//  fifo_dout     in   9      {del, byte}; valid the cycle after fifo_rden (1-cycle read latency)
//  fifo_empty    in   1      FIFO empty flag
//  fifo_rden     out  1      read strobe; combinational from registered state and fifo_empty
//  mii_tx_en     out  1      MII TX_EN, registered
//  mii_txd       out  4      MII TXD, registered
//  mii_tx_er     out  1      MII TX_ER, registered
//  busy          out  1      state != IDLE
//  frame_cnt     out  CNT_W  frames completed; only with PHY_TX_STATS_EN
//  underrun_cnt  out  CNT_W  frames aborted on underrun; only with PHY_TX_STATS_EN
// BEHAVIOUR
//  Reset: state IDLE; fifo_rden=0, mii_tx_en=0, mii_txd=0, mii_tx_er=0, busy=0, counters=0.
//  Reset asserted mid-frame: outputs drop to 0 immediately; FIFO contents are untouched (upper layer flushes).
//  MII outputs are registered: the nibble decided in cycle t appears at cycle t+1.
//  States:
//   IDLE   if enable && !fifo_empty -> PRE, nib_cnt=0.
//   PRE    drive 0x5 with tx_en=1; fifo_rden=1 when nib_cnt==PRE_NIBBLES-1; then -> SFD.
//   SFD    drive 0xD; capture hold<=fifo_dout; -> DLO.
//   DLO    drive hold[3:0]; if !hold.del && !fifo_empty then fifo_rden=1;
//          if !hold.del && fifo_empty, latch the underrun flag; -> DHI.
//   DHI    drive hold[7:4]; hold.del -> IFG (frame done);
//          underrun flag -> ABT; else hold<=fifo_dout -> DLO.
//   ABT    one nibble with tx_en=1, tx_er=1, txd=0 -> DRN.
//   DRN    tx_en=0; fifo_rden=1 whenever !fifo_empty; a returned word with del=1 ends the drain -> IFG.
//   IFG    tx_en=0 for IFG_NIBBLES cycles, counted from the cycle after the last nibble -> IDLE.
//  Latency: IDLE with data present to first mii_tx_en = 2 cycles; 64-byte frame = 15+1+128 = 144 tx_en nibbles.
//  Back-to-back frames: the next preamble starts exactly IFG_NIBBLES cycles after the previous tx_en falls.
//  enable falling mid-frame has no effect until IDLE.
//  del on the first byte is legal: a 1-byte frame is emitted (no padding; length is the upstream's job).
//  nib_cnt is 5 bits; no wrap within any state.
// CONFIGURATION
//  PHY_TX_STATS_EN defined:
//   - frame_cnt increments on the DHI->IFG transition.
//   - underrun_cnt increments on the DHI->ABT transition.
//   - Both wrap modulo 2^CNT_W.
//  PHY_TX_STATS_EN undefined: both ports are absent and no counter logic is generated; behaviour is otherwise identical.
// STRUCTURE
//  Shared package phy_tx_pkg:
//   - state encodings (3-bit): IDLE, PRE, SFD, DLO, DHI, ABT, DRN, IFG
//   - NIB_PRE=4'h5, NIB_SFD=4'hD
//   - FIFO word layout constant DEL_BIT=8
//  Sub-module phy_tx_stat_ctr (wrapping CNT_W counter with increment enable), instantiated twice under PHY_TX_STATS_EN.
//  FSM, hold register and MII output registers stay in this module.
// TESTING
//  1. FIFO preloaded with 64 bytes 0x00..0x3F, del on the last byte, enable=1
//     -> 15x 0x5, one 0xD, then 0,0,1,0,2,0 ... F,3 nibbles; tx_en high for 144 cycles; tx_er never asserts.
//  2. Two 64-byte frames back to back
//     -> tx_en low for exactly 24 cycles between frames; frame_cnt=2.
//  3. FIFO goes empty after byte 10 of a frame (no del seen)
//     -> after byte 10's high nibble, one nibble tx_en=1/tx_er=1, then tx_en=0.
//     Late-arriving bytes are drained through del; underrun_cnt=1; the next frame is clean.
//  4. enable=0 with data queued -> no fifo_rden, tx_en stays 0.
//     enable dropped mid-frame -> the frame completes and no new frame starts.
//  5. arst_n pulsed low at nibble 40 of a frame -> all outputs 0 in that cycle; busy=0; after release, a new frame starts cleanly.
//  6. Build without PHY_TX_STATS_EN -> elaborates without counter ports; scenarios 1 to 4 give identical MII waveforms.

Source files
------------

// File: rtl/phy_tx_pkg.sv
// Shared encodings for the PHY-TX MII framer: FSM states, fixed nibbles and FIFO word layout.
package phy_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DLO  = 3'd3,
        ST_DHI  = 3'd4,
        ST_ABT  = 3'd5,
        ST_DRN  = 3'd6,
        ST_IFG  = 3'd7
    } state_e;

    localparam logic [3:0] NIB_PRE = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hD;
    localparam int         DEL_BIT = 8;

endpackage

// File: rtl/phy_tx_stat_ctr.sv
// Wrapping statistics counter with a single-cycle increment enable.
module phy_tx_stat_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = inc_i ? cnt_q + CNT_W'(1) : cnt_q;
    assign cnt_o = cnt_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phy_tx_mii_framer.sv
// Drains the PHY-TX FIFO onto a 100 Mb/s MII: preamble/SFD insertion, nibble serialisation,
// underrun abort with drain, and inter-frame gap. Define PHY_TX_STATS_EN for frame/underrun counters.
module phy_tx_mii_framer
    import phy_tx_pkg::*;
#(
    parameter int PRE_NIBBLES = 15,
    parameter int IFG_NIBBLES = 24,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic [8:0]       fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rden,
    output logic             mii_tx_en,
    output logic [3:0]       mii_txd,
    output logic             mii_tx_er,
    output logic             busy
`ifdef PHY_TX_STATS_EN
    ,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] underrun_cnt
`endif
);

    localparam logic [4:0] PRE_LAST = 5'(PRE_NIBBLES - 1);
    // The mandatory IDLE cycle before PRE supplies the final gap nibble.
    localparam logic [4:0] IFG_LAST = 5'(IFG_NIBBLES - 2);

    state_e     state_q;
    logic [4:0] nib_cnt_q;
    logic [8:0] hold_q;
    logic       urun_q;
    logic       rd_pend_q;
    logic       tx_en_q;
    logic       tx_er_q;
    logic [3:0] txd_q;

    logic       hold_del;
    logic       drain_done;

    assign hold_del   = hold_q[DEL_BIT];
    assign drain_done = rd_pend_q && fifo_dout[DEL_BIT];

    assign mii_tx_en = tx_en_q;
    assign mii_txd   = txd_q;
    assign mii_tx_er = tx_er_q;
    assign busy      = (state_q != ST_IDLE);

    // While draining, hold off the read in the cycle the tail word returns so the next frame's head stays queued.
    always_comb begin
        fifo_rden = 1'b0;
        case (state_q)
            ST_PRE:  fifo_rden = (nib_cnt_q == PRE_LAST);
            ST_DLO:  fifo_rden = !hold_del && !fifo_empty;
            ST_DRN:  fifo_rden = !fifo_empty && !drain_done;
            default: fifo_rden = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_IDLE;
            nib_cnt_q <= '0;
            hold_q    <= '0;
            urun_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            txd_q     <= '0;
        end else begin
            rd_pend_q <= fifo_rden;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            txd_q     <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (enable && !fifo_empty) begin
                        state_q   <= ST_PRE;
                        nib_cnt_q <= '0;
                    end
                end
                ST_PRE: begin
                    tx_en_q   <= 1'b1;
                    txd_q     <= NIB_PRE;
                    nib_cnt_q <= nib_cnt_q + 5'd1;
                    if (nib_cnt_q == PRE_LAST) begin
                        state_q <= ST_SFD;
                    end
                end
                ST_SFD: begin
                    tx_en_q <= 1'b1;
                    txd_q   <= NIB_SFD;
                    hold_q  <= fifo_dout;
                    urun_q  <= 1'b0;
                    state_q <= ST_DLO;
                end
                ST_DLO: begin
                    tx_en_q <= 1'b1;
                    txd_q   <= hold_q[3:0];
                    if (!hold_del && fifo_empty) begin
                        urun_q <= 1'b1;
                    end
                    state_q <= ST_DHI;
                end
                ST_DHI: begin
                    tx_en_q <= 1'b1;
                    txd_q   <= hold_q[7:4];
                    if (hold_del) begin
                        state_q   <= ST_IFG;
                        nib_cnt_q <= '0;
                    end else if (urun_q) begin
                        state_q <= ST_ABT;
                    end else begin
                        hold_q  <= fifo_dout;
                        state_q <= ST_DLO;
                    end
                end
                ST_ABT: begin
                    tx_en_q <= 1'b1;
                    tx_er_q <= 1'b1;
                    state_q <= ST_DRN;
                end
                ST_DRN: begin
                    if (drain_done) begin
                        state_q   <= ST_IFG;
                        nib_cnt_q <= '0;
                    end
                end
                ST_IFG: begin
                    nib_cnt_q <= nib_cnt_q + 5'd1;
                    if (nib_cnt_q == IFG_LAST) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef PHY_TX_STATS_EN
    logic frame_inc;
    logic urun_inc;

    assign frame_inc = (state_q == ST_DHI) && hold_del;
    assign urun_inc  = (state_q == ST_DHI) && !hold_del && urun_q;

    phy_tx_stat_ctr #(.CNT_W(CNT_W)) u_frame_ctr (
        .clk    (clk),
        .arst_n (arst_n),
        .inc_i  (frame_inc),
        .cnt_o  (frame_cnt)
    );

    phy_tx_stat_ctr #(.CNT_W(CNT_W)) u_urun_ctr (
        .clk    (clk),
        .arst_n (arst_n),
        .inc_i  (urun_inc),
        .cnt_o  (underrun_cnt)
    );
`endif

endmodule

// File: tb/tb_phy_tx_mii_framer.sv
// Directed bench for phy_tx_mii_framer with a behavioural 1-cycle-latency FIFO model.
`timescale 1ns/1ps
module tb_phy_tx_mii_framer;

    localparam int CNT_W = 16;

    logic       clk    = 1'b0;
    logic       arst_n = 1'b0;
    logic       enable = 1'b0;
    logic [8:0] fifo_dout = '0;
    logic       fifo_empty;
    logic       fifo_rden;
    logic       mii_tx_en;
    logic [3:0] mii_txd;
    logic       mii_tx_er;
    logic       busy;
`ifdef PHY_TX_STATS_EN
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] underrun_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] mem [0:1023];
    int   wr_ptr    = 0;
    int   rd_ptr    = 0;
    logic flush_req = 1'b0;
    int   rden_cnt  = 0;
    int   txen_cnt  = 0;

    always #20 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rden && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
        end
        if (fifo_rden) rden_cnt <= rden_cnt + 1;
        if (mii_tx_en) txen_cnt <= txen_cnt + 1;
    end

    phy_tx_mii_framer #(
        .PRE_NIBBLES (15),
        .IFG_NIBBLES (24),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .enable       (enable),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rden    (fifo_rden),
        .mii_tx_en    (mii_tx_en),
        .mii_txd      (mii_txd),
        .mii_tx_er    (mii_tx_er),
        .busy         (busy)
`ifdef PHY_TX_STATS_EN
        ,
        .frame_cnt    (frame_cnt),
        .underrun_cnt (underrun_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic del, input logic [7:0] b);
        mem[wr_ptr[9:0]] = {del, b};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_frame(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) push(i == n - 1, base + 8'(i));
    endtask

    task automatic wait_txen(input int limit, output int waited);
        waited = 0;
        while (!mii_tx_en && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Starts at the negedge showing nibble 0; leaves time at the last nibble checked.
    task automatic check_frame(input string tag, input int n, input logic [7:0] base, input int max_nibs);
        int lim;
        lim = 16 + 2 * n;
        if (max_nibs < lim) lim = max_nibs;
        for (int k = 0; k < lim; k++) begin
            logic [5:0] exp;
            logic [7:0] b;
            b = base + 8'((k - 16) / 2);
            if (k < 15)       exp = {2'b10, 4'h5};
            else if (k == 15) exp = {2'b10, 4'hD};
            else              exp = {2'b10, ((k % 2) == 0) ? b[3:0] : b[7:4]};
            if (k > 0) @(negedge clk);
            check_val($sformatf("%s_nib%0d", tag, k), {26'd0, mii_tx_en, mii_tx_er, mii_txd}, {26'd0, exp});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int gap;
        int r0;
        int t0;

        repeat (3) @(negedge clk);
        check_val("rst_tx_en", mii_tx_en, 0);
        check_val("rst_txd", mii_txd, 0);
        check_val("rst_tx_er", mii_tx_er, 0);
        check_val("rst_rden", fifo_rden, 0);
        check_val("rst_busy", busy, 0);
`ifdef PHY_TX_STATS_EN
        check_val("rst_frame_cnt", frame_cnt, 0);
        check_val("rst_urun_cnt", underrun_cnt, 0);
`endif
        arst_n = 1'b1;
        @(negedge clk);

        // Scenario 1: single 64-byte frame
        enable = 1'b1;
        push_frame(64, 8'h00);
        wait_txen(200, w);
        check_val("s1_latency", w, 2);
        check_val("s1_busy", busy, 1);
        check_frame("s1", 64, 8'h00, 999);
        @(negedge clk);
        check_val("s1_txen_fall", mii_tx_en, 0);

        // Scenario 2: two frames back to back
        push_frame(64, 8'h40);
        push_frame(64, 8'h80);
        wait_txen(200, w);
        check_val("s2a_start", mii_tx_en, 1);
        check_frame("s2a", 64, 8'h40, 999);
        gap = 0;
        @(negedge clk);
        while (!mii_tx_en && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        check_val("s2_ifg_gap", gap, 24);
        check_frame("s2b", 64, 8'h80, 999);
        @(negedge clk);
        check_val("s2_txen_fall", mii_tx_en, 0);
`ifdef PHY_TX_STATS_EN
        check_val("s2_frame_cnt", frame_cnt, 3);
`endif

        // Scenario 3: underrun after byte 10, late bytes drained, next frame clean
        for (int i = 0; i < 10; i++) push(1'b0, 8'hA0 + 8'(i));
        wait_txen(200, w);
        check_val("s3_start", mii_tx_en, 1);
        check_frame("s3", 10, 8'hA0, 999);
        @(negedge clk);
        check_val("s3_abort_nib", {mii_tx_en, mii_tx_er, mii_txd}, 6'b110000);
        @(negedge clk);
        check_val("s3_after_abort", {mii_tx_en, mii_tx_er}, 2'b00);
        check_val("s3_busy_drain", busy, 1);
        for (int i = 0; i < 5; i++) push(i == 4, 8'hB0 + 8'(i));
        push_frame(8, 8'h30);
        wait_txen(300, w);
        check_val("s3n_start", mii_tx_en, 1);
        check_frame("s3n", 8, 8'h30, 999);
        @(negedge clk);
        check_val("s3n_txen_fall", mii_tx_en, 0);
        check_val("s3_fifo_drained", fifo_empty, 1);
`ifdef PHY_TX_STATS_EN
        check_val("s3_urun_cnt", underrun_cnt, 1);
        check_val("s3_frame_cnt", frame_cnt, 4);
`endif

        // Scenario 4: enable low holds off; enable dropped mid-frame lets it finish
        enable = 1'b0;
        r0 = rden_cnt;
        t0 = txen_cnt;
        push_frame(4, 8'h60);
        repeat (60) @(negedge clk);
        check_val("s4_no_rden", rden_cnt - r0, 0);
        check_val("s4_no_txen", txen_cnt - t0, 0);
        check_val("s4_idle", busy, 0);
        enable = 1'b1;
        wait_txen(10, w);
        check_val("s4_latency", w, 2);
        push_frame(64, 8'h40);
        enable = 1'b0;
        check_frame("s4a", 4, 8'h60, 999);
        @(negedge clk);
        r0 = rden_cnt;
        t0 = txen_cnt;
        repeat (60) @(negedge clk);
        check_val("s4_hold_rden", rden_cnt - r0, 0);
        check_val("s4_hold_txen", txen_cnt - t0, 0);
`ifdef PHY_TX_STATS_EN
        check_val("s4_frame_cnt", frame_cnt, 5);
`endif

        // Scenario 5: async reset at nibble 40, then a clean 1-byte frame
        enable = 1'b1;
        wait_txen(10, w);
        check_val("s5_start", mii_tx_en, 1);
        check_frame("s5", 64, 8'h40, 41);
        arst_n = 1'b0;
        #1;
        check_val("s5_rst_tx_en", mii_tx_en, 0);
        check_val("s5_rst_txd", mii_txd, 0);
        check_val("s5_rst_tx_er", mii_tx_er, 0);
        check_val("s5_rst_rden", fifo_rden, 0);
        check_val("s5_rst_busy", busy, 0);
`ifdef PHY_TX_STATS_EN
        check_val("s5_rst_frame_cnt", frame_cnt, 0);
`endif
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        arst_n = 1'b1;
        check_val("s5_flushed", fifo_empty, 1);
        push_frame(1, 8'hC3);
        wait_txen(10, w);
        check_val("s5n_latency", w, 2);
        check_frame("s5n", 1, 8'hC3, 999);
        @(negedge clk);
        check_val("s5n_txen_fall", mii_tx_en, 0);
`ifdef PHY_TX_STATS_EN
        check_val("s5n_frame_cnt", frame_cnt, 1);
        check_val("s5n_urun_cnt", underrun_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
